// File: rtl/fifo_rd_checker_pkg.sv
// Shared definitions for the FIFO test datapath: LFSR constants, the step
// function used by both the write-side generator and the read-side checker, and FSM states.
package fifo_rd_checker_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'h0AA1;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (zero-based bit indices)
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
    return {v[LFSR_WIDTH-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
  endfunction

endpackage

// File: rtl/fifo_rd_checker_lfsr_step.sv
// Registered Fibonacci LFSR with a synchronous seed load and an advance strobe;
// exposes the low DATA_W bits as the expected data word.
module fifo_rd_checker_lfsr_step
  import fifo_rd_checker_pkg::*;
#(
  parameter int              W      = LFSR_WIDTH,
  parameter int              DATA_W = 8,
  parameter logic [W-1:0]    SEED   = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  output logic [DATA_W-1:0] exp_byte
);

  logic [W-1:0] lfsr;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= SEED;
    else if (load) lfsr <= SEED;
    else if (adv)  lfsr <= lfsr_next(lfsr);
  end

  assign exp_byte = lfsr[DATA_W-1:0];

endmodule

// File: rtl/fifo_rd_checker.sv
// Read-side FIFO consumer: pops while non-empty, compares each word against a
// locally regenerated LFSR stream and reports counts and first-mismatch details.
module fifo_rd_checker
  import fifo_rd_checker_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LFSR_W    = LFSR_WIDTH,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_SEED,
  parameter int                NUM_WORDS = 1024,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  output logic              rd,
  input  logic [DATA_W-1:0] d_in,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_flag,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(NUM_WORDS - 1);
  localparam bit               BOUNDED = (NUM_WORDS != 0);

  state_t            state, state_nxt;
  logic              rd_q;
  logic [CNT_W-1:0]  issued;
  logic [DATA_W-1:0] exp_byte;
  logic              last_rd;

  fifo_rd_checker_lfsr_step #(
    .W      (LFSR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .adv      (rd_q),
    .exp_byte (exp_byte)
  );

  assign rd      = (state == RUN) && enable && !empty;
  assign last_rd = BOUNDED && (issued == LAST_RD);
  assign done    = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)         state_nxt = RUN;
      RUN:     if (rd && last_rd)  state_nxt = DRAIN;
      DRAIN:   if (rd_q)           state_nxt = DONE;
      DONE:                        state_nxt = DONE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // rd_q marks the cycle in which d_in carries the word popped one cycle earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q          <= 1'b0;
      issued        <= '0;
      rd_count      <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      rd_q <= rd;
      if (rd && issued != CNT_MAX) issued <= issued + 1'b1;
      if (rd_q) begin
        if (rd_count != CNT_MAX) rd_count <= rd_count + 1'b1;
        if (d_in != exp_byte) begin
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
          if (!err_flag) begin
            err_flag      <= 1'b1;
            first_err_exp <= exp_byte;
            first_err_got <= d_in;
          end
        end
      end
    end
  end

endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
- Read-side consumer for the async FIFO testbench datapath; sits directly downstream of the FIFO read port.
- Pops words whenever the FIFO is non-empty and regenerates the expected byte stream with a local LFSR seeded identically to the write-side generator.
- Compares every popped word against the expected byte and reports read count, error count and first-mismatch details.
- Synthesizable, so it can also run on silicon/FPGA as a built-in self-check.

Parameters:
- DATA_W, 8, FIFO data width; compared against LFSR bits [DATA_W-1:0].
- LFSR_W, 16, LFSR width.
- SEED, 16'h0AA1, LFSR value after reset; equals the write-side seed.
- NUM_WORDS, 1024, words to check before entering DONE; 0 = run forever.
- CNT_W, 16, width of the read and error counters.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits reads while high.
- empty  in  1  FIFO empty flag, read-clock domain.
- rd  out  1  FIFO pop strobe.
- d_in  in  DATA_W  FIFO read data, valid the cycle after rd.
- rd_count  out  CNT_W  words compared so far, saturating.
- err_count  out  CNT_W  mismatches so far, saturating.
- err_flag  out  1  sticky; set on the first mismatch.
- first_err_exp  out  DATA_W  expected byte at the first mismatch.
- first_err_got  out  DATA_W  received byte at the first mismatch.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, active-high):
  - lfsr=SEED; state=IDLE.
  - rd, rd_q, done, err_flag = 0.
  - rd_count, err_count, first_err_exp, first_err_got = 0.
- LFSR: Fibonacci, shift left; new bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1). Expected byte = lfsr[DATA_W-1:0]. Advance only on a compare cycle.
- rd is combinational: rd = (state==RUN) && enable && !empty.
- rd_q is rd registered.
- Read latency:
  - rd in cycle N → compare d_in in cycle N+1, when rd_q=1.
  - Back-to-back reads give one compare per cycle.
- Compare cycle:
  - rd_count++.
  - On mismatch: err_count++.
  - If err_flag was 0: set err_flag and capture first_err_exp/first_err_got.
  - lfsr advances.
  - All updates are registered and visible at N+2.
- Counters saturate at all-ones and never wrap.
- FSM:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when a read is issued and that read brings issued-read count to NUM_WORDS; no further rd after that read.
  - DRAIN → DONE on the final compare cycle.
  - DONE holds until rst. rd=0, done=1.
  - With NUM_WORDS=0, RUN never exits.
- enable deasserted in RUN: rd drops the same cycle; a pending rd_q compare still completes; state stays RUN.
- empty asserts while rd_q pending: compare still completes; no new rd until empty=0.
- An issued-read counter (CNT_W bits) is tracked separately from rd_count for the NUM_WORDS termination.
- rst mid-transfer: everything returns to reset values immediately; any pending compare is discarded.

Decomposition:
- Shared package (also used by the write-side generator): LFSR_W, SEED, the tap constants, and an lfsr_next function.
- Shared package also holds the FSM state enum (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: lfsr_step, a registered LFSR with load-seed and advance inputs.
- The counters and FSM stay in the top-level block.

Test Plan:
- Reset then enable=1, empty=0, d_in fed 0xA1, 0x42, 0x84 on successive compare cycles → rd asserted three consecutive cycles, rd_count=3, err_count=0, err_flag=0.
- Same as above but second word forced to 0x43 → err_count=1, err_flag=1, first_err_exp=0x42, first_err_got=0x43; third word 0x84 still passes, confirming the LFSR advanced.
- NUM_WORDS=4, empty toggled 1/0 every cycle with correct data → rd only when empty=0, exactly 4 reads, then done=1 and rd=0 forever; rd_count=4.
- enable dropped the cycle after a rd → the pending compare completes (rd_count increments), no new rd; re-enable resumes with the next expected byte.
- Assert rst while in RUN with err_count=2 → same cycle: rd=0, counters=0, err_flag=0. After release, the first expected byte is 0xA1 again.
- Force 0xFFFF mismatches (CNT_W=16) → err_count saturates at 0xFFFF and does not wrap.
